ysyx_22050243_if_id: RTL

IF/ID pipeline register for the 64-bit RISC-V core. It sits between the fetch stage and decode. It registers the fetch bus {ce, pc, next_pc} and pairs the registered PC with the instruction word that the synchronous I-SRAM returns one cycle after the address.
It holds that pair across pipeline stalls, including capturing the SRAM word on the first stall cycle, because the SRAM output changes while fetch keeps presenting its own PC. On flush it injects a NOP bubble.

---
 rtl/ysyx_22050243_if_id.sv | 100 ++++++++++
 1 files changed

// File: rtl/ysyx_22050243_if_id.sv
// IF/ID pipeline register: pairs the registered fetch PC with the I-SRAM word
// that arrives a cycle later. The pair is held across stalls, and a flush inserts a NOP bubble.
module ysyx_22050243_if_id #(
    parameter int          XLEN     = 64,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           stall,
    input  logic                 flush,
    input  logic [2*XLEN:0]      if_to_id_bus,
    input  logic [31:0]          isram_rdata,
    output logic [2*XLEN+32:0]   id_bus,
    output logic                 id_valid,
    output logic [CNT_W-1:0]     stall_cnt
);

    logic            hold;
    logic            ce;
    logic [XLEN-1:0] pc_in, npc_in;

    logic            v_q, v_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] npc_q, npc_d;
    logic            hold_v_q, hold_v_d;
    logic [31:0]     hold_inst_q, hold_inst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]     inst;
    logic            unused_stall_bits;

    // Must match the fetch stage's PC-hold term, or the SRAM word and PC drift apart.
    assign hold   = stall[0] | stall[1] | stall[3];
    assign ce     = if_to_id_bus[2*XLEN];
    assign pc_in  = if_to_id_bus[2*XLEN-1:XLEN];
    assign npc_in = if_to_id_bus[XLEN-1:0];
    assign unused_stall_bits = ^{stall[5:4], stall[2]};

    always_comb begin
        v_d         = v_q;
        pc_d        = pc_q;
        npc_d       = npc_q;
        hold_v_d    = hold_v_q;
        hold_inst_d = hold_inst_q;
        cnt_d       = cnt_q;
        if (flush) begin
            v_d         = 1'b0;
            pc_d        = '0;
            npc_d       = '0;
            hold_v_d    = 1'b0;
            hold_inst_d = NOP_INST;
        end else if (hold) begin
            // The SRAM output only belongs to pc_q on the first stall cycle.
            if (!hold_v_q) begin
                hold_v_d    = 1'b1;
                hold_inst_d = isram_rdata;
            end
            if (v_q && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            v_d      = ce;
            pc_d     = pc_in;
            npc_d    = npc_in;
            hold_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q         <= 1'b0;
            pc_q        <= '0;
            npc_q       <= '0;
            hold_v_q    <= 1'b0;
            hold_inst_q <= NOP_INST;
            cnt_q       <= '0;
        end else begin
            v_q         <= v_d;
            pc_q        <= pc_d;
            npc_q       <= npc_d;
            hold_v_q    <= hold_v_d;
            hold_inst_q <= hold_inst_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        inst = isram_rdata;
        if (!v_q) begin
            inst = NOP_INST;
        end else if (hold_v_q) begin
            inst = hold_inst_q;
        end
    end

    assign id_bus    = {v_q, pc_q, inst, npc_q};
    assign id_valid  = v_q;
    assign stall_cnt = cnt_q;

endmodule
